// File: rtl/day_clock_pkg.sv
// day_clock_pkg: shared constants, types and helpers for the day_clock time base.
//   TW_DEF / DW_DEF : default minute / day counter widths
//   minute_t, day_t : default-width minute and day types
//   last_minute()   : last minute index of a day for a given period (0 => 2^tw)
package day_clock_pkg;

    localparam int TW_DEF = 11;
    localparam int DW_DEF = 8;

    typedef logic [TW_DEF-1:0] minute_t;
    typedef logic [DW_DEF-1:0] day_t;

    // Returns period-1, or 2^tw-1 when period is 0. The result is one bit wider
    // than any tw <= 31 so callers can size-cast it to TW+1 bits without loss.
    function automatic logic [32:0] last_minute(input logic [31:0] period,
                                                input int unsigned tw);
        logic [32:0] r;
        if (period == '0) r = (33'd1 << tw) - 33'd1;
        else              r = {1'b0, period} - 33'd1;
        return r;
    endfunction

endpackage

// File: rtl/day_clock_tick_gen.sv
// tick_gen: minute prescaler.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the prescaler
//   clr        : restart the prescaler phase (takes priority over en)
//   tick       : high in an enabled cycle where the prescaler sits at PRESCALE-1
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A cleared cycle never ticks, so the caller need not mask it again.
    assign tick = en && !clr && (cnt_q == TOP);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/day_clock.sv
// day_clock: programmable minute/day time base with alarm channels.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : count enable (freezes prescaler and counters when low)
//   period      : minutes per day, 0 means 2^TW
//   load        : overwrite minute with load_val (clamped to 0 if beyond the day)
//   alarm_time  : per-channel alarm minute; alarm_en: per-channel enable
//   minute, day : current minute of day, days elapsed (wraps)
//   tick        : pulse when a minute tick advanced the count
//   day_end     : pulse on minute wrap to 0
//   alarm_hit   : per-channel pulse when the count lands on alarm_time
module day_clock
    import day_clock_pkg::*;
#(
    parameter int TW       = 11,
    parameter int DW       = 8,
    parameter int PRESCALE = 1,
    parameter int NALARM   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [TW-1:0]              period,
    input  logic                       load,
    input  logic [TW-1:0]              load_val,
    input  logic [NALARM-1:0][TW-1:0]  alarm_time,
    input  logic [NALARM-1:0]          alarm_en,
    output logic [TW-1:0]              minute,
    output logic [DW-1:0]              day,
    output logic                       tick,
    output logic                       day_end,
    output logic [NALARM-1:0]          alarm_hit
);

    typedef logic [TW:0] ext_t;

    logic              ptick;
    ext_t              last;
    logic              at_last;
    logic              load_ok;
    logic [TW-1:0]     next_min;

    logic [TW-1:0]     minute_q, minute_d;
    logic [DW-1:0]     day_q, day_d;
    logic              tick_q, tick_d;
    logic              day_end_q, day_end_d;
    logic [NALARM-1:0] hit_q, hit_d;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .tick  (ptick)
    );

    // Compared one bit wider so period=0 (2^TW minutes) needs no special case,
    // and a minute already beyond a freshly lowered period wraps on the next tick.
    assign last     = ext_t'(last_minute(32'(period), TW));
    assign at_last  = {1'b0, minute_q} >= last;
    assign load_ok  = {1'b0, load_val} <= last;
    assign next_min = at_last ? '0 : minute_q + 1'b1;

    always_comb begin
        minute_d  = minute_q;
        day_d     = day_q;
        tick_d    = 1'b0;
        day_end_d = 1'b0;
        if (load) begin
            minute_d = load_ok ? load_val : '0;
        end else if (ptick) begin
            minute_d = next_min;
            tick_d   = 1'b1;
            if (at_last) begin
                day_d     = day_q + 1'b1;
                day_end_d = 1'b1;
            end
        end
    end

    // ptick is already suppressed in load cycles.
    for (genvar i = 0; i < NALARM; i++) begin : g_alarm
        assign hit_d[i] = ptick && alarm_en[i] && (next_min == alarm_time[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            minute_q  <= '0;
            day_q     <= '0;
            tick_q    <= 1'b0;
            day_end_q <= 1'b0;
            hit_q     <= '0;
        end else begin
            minute_q  <= minute_d;
            day_q     <= day_d;
            tick_q    <= tick_d;
            day_end_q <= day_end_d;
            hit_q     <= hit_d;
        end
    end

    assign minute    = minute_q;
    assign day       = day_q;
    assign tick      = tick_q;
    assign day_end   = day_end_q;
    assign alarm_hit = hit_q;

endmodule
